ps2_key_tracker: RTL and testbench
==================================

Name: ps2_key_tracker

Overview:
- Parametrised successor to the single-key PS/2 display decoder.
- Consumes received PS/2 scan-code bytes from the receiver.
- Decodes make, break, E0-extended and E1-Pause sequences.
- Tracks up to MAX_KEYS simultaneously held keys, filters typematic repeats, and counts fresh presses.
- Feeds the seven-segment display path and any downstream key consumer.

Parameters:
- MAX_KEYS, 4, held-key table depth (1..16).
- CNT_W, 8, width of the fresh-press counter.
- PAUSE_LEN, 7, number of bytes following E1 to swallow for the Pause key.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- ps2_data  in  8  received scan-code byte.
- ps2_valid  in  1  one-cycle strobe; ps2_data is valid while high.
- key_evt  out  1  one-cycle pulse; a complete key event is reported.
- key_code  out  8  scan code of the last event.
- key_ext  out  1  last event was E0-prefixed.
- key_down  out  1  1 = make, 0 = break, for the last event.
- key_repeat  out  1  last make was a typematic repeat of an already-held key.
- pause_evt  out  1  one-cycle pulse when the full Pause sequence has been consumed.
- any_held  out  1  at least one table entry is valid; drives the display enable.
- held_cnt  out  $clog2(MAX_KEYS+1)  number of valid table entries.
- press_cnt  out  CNT_W  count of fresh (non-repeat) makes.
- overflow  out  1  sticky; a fresh make arrived while the table was full.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to S_BASE; table valid bits are cleared.
  - All outputs are 0; pause counter is 0.
  - Reset mid-sequence discards any partial prefix.
- FSM states: S_BASE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE. Transitions occur only on ps2_valid=1; otherwise the state holds.
  - S_BASE:
    - E0 -> S_EXT.
    - F0 -> S_BRK.
    - E1 -> S_PAUSE, with pause counter loaded to PAUSE_LEN.
    - Any other byte is a make with ext=0; stay in S_BASE.
  - S_EXT:
    - F0 -> S_EXT_BRK.
    - E0 -> stay in S_EXT (a duplicate prefix is tolerated).
    - Any other byte is a make with ext=1 -> S_BASE.
  - S_BRK: any byte is a break with ext=0 -> S_BASE.
  - S_EXT_BRK: any byte is a break with ext=1 -> S_BASE.
  - S_PAUSE:
    - Each byte decrements the counter.
    - When the counter reaches 0, pulse pause_evt and return to S_BASE.
    - Pause never enters the table and never generates key_evt.
- Event timing:
  - key_evt rises in the cycle after the ps2_valid that completes the sequence.
  - key_code, key_ext, key_down and key_repeat update in that same cycle and hold until the next event.
  - Prefix bytes (E0, F0, E1) never produce key_evt.
- Make handling (table match is on {ext, code}):
  - Entry already valid: key_repeat=1; press_cnt and the table are unchanged.
  - Not present, free slot exists: write the entry at the lowest-index free slot; press_cnt increments (wraps modulo 2^CNT_W); key_repeat=0.
  - Not present, table full: overflow is set (sticky until reset); press_cnt still increments; the key is not stored; key_repeat=0.
- Break handling:
  - Clear the matching entry if present. If none matches, the table is unchanged.
  - key_evt is pulsed in both cases, with key_down=0 and key_repeat=0.
- held_cnt and any_held are registered and reflect the table in the same cycle as key_evt.
- Table insertion and removal never occur in the same cycle, since ps2_valid delivers at most one byte per cycle.
- ps2_valid held high for consecutive cycles is processed as one byte per cycle.

Decomposition:
- Shared package ps2_pkg holds:
  - Constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1.
  - The FSM state enum.
  - A key_entry_t struct {valid, ext, code[7:0]}.
- One natural sub-module, ps2_key_table: a MAX_KEYS-entry CAM that provides lookup hit/index, lowest-free index, full flag, insert/remove ports, and held count.
- The FSM, counters and output registers stay in the top module.

Test Plan:
- Bytes 1C, F0, 1C:
  - key_evt after the 1C with code=1C, down=1, ext=0; any_held=1, press_cnt=1.
  - After F0 1C: down=0, any_held=0, held_cnt=0.
- Bytes E0 75, E0 F0 75:
  - Make with ext=1, code=75, held_cnt=1.
  - Break with ext=1, after which held_cnt=0.
  - No key_evt on the E0 or F0 bytes.
- Bytes 1C, 1C, 1C (typematic): three key_evt; the 2nd and 3rd have key_repeat=1; press_cnt=1, held_cnt=1.
- MAX_KEYS=4, makes 1C 1B 23 2B 34:
  - held_cnt=4, overflow=1, press_cnt=5.
  - Then F0 1B followed by make 34: slot 1 is reused, held_cnt=4.
- Bytes E1 14 77 E1 F0 14 F0 77: a single pause_evt after the 8th byte; no key_evt; state is back to S_BASE (a following 1C decodes as a make).
- rst asserted between F0 and the code byte:
  - Outputs clear asynchronously and the table is empty.
  - A following 1C decodes as a make, not a break.

Source files
------------

// File: rtl/ps2_key_tracker_pkg.sv
// ps2_pkg: shared scan-code constants, decoder state enum and held-key entry type
package ps2_pkg;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  typedef enum logic [2:0] {S_BASE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} state_t;
  typedef struct packed {
    logic       valid;
    logic       ext;
    logic [7:0] code;
  } key_entry_t;
endpackage

// File: rtl/ps2_key_tracker_if.sv
// ps2_key_tracker_if: byte input from the PS/2 receiver and decoded key/status outputs; master = bus driver, slave = tracker
interface ps2_key_tracker_if #(parameter int MAX_KEYS = 4, parameter int CNT_W = 8);
  logic [7:0]                      ps2_data;
  logic                            ps2_valid;
  logic                            key_evt;
  logic [7:0]                      key_code;
  logic                            key_ext;
  logic                            key_down;
  logic                            key_repeat;
  logic                            pause_evt;
  logic                            any_held;
  logic [$clog2(MAX_KEYS+1)-1:0]   held_cnt;
  logic [CNT_W-1:0]                press_cnt;
  logic                            overflow;
  modport master (output ps2_data, ps2_valid,
                  input key_evt, key_code, key_ext, key_down, key_repeat, pause_evt, any_held, held_cnt, press_cnt, overflow);
  modport slave (input ps2_data, ps2_valid,
                 output key_evt, key_code, key_ext, key_down, key_repeat, pause_evt, any_held, held_cnt, press_cnt, overflow);
endinterface

// File: rtl/ps2_key_tracker_key_table.sv
// ps2_key_table: MAX_KEYS-entry CAM of held {ext,code}; ports: key_i lookup key, hit_o/hit_idx_o match, free_idx_o lowest free slot, full_o, ins_i/rem_i write at idx_i, held_cnt_o valid count
module ps2_key_table
  import ps2_pkg::*;
#(
  parameter int MAX_KEYS = 4,
  localparam int IW = (MAX_KEYS > 1) ? $clog2(MAX_KEYS) : 1,
  localparam int HW = $clog2(MAX_KEYS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [8:0]    key_i,
  input  logic          ins_i,
  input  logic          rem_i,
  input  logic [IW-1:0] idx_i,
  output logic          hit_o,
  output logic [IW-1:0] hit_idx_o,
  output logic [IW-1:0] free_idx_o,
  output logic          full_o,
  output logic [HW-1:0] held_cnt_o
);
  key_entry_t tab_q [MAX_KEYS];
  // Scan downwards so the lowest matching / free index wins.
  always_comb begin
    hit_o = 1'b0;
    hit_idx_o = '0;
    free_idx_o = '0;
    full_o = 1'b1;
    held_cnt_o = '0;
    for (int i = MAX_KEYS - 1; i >= 0; i--) begin
      if (tab_q[i].valid && {tab_q[i].ext, tab_q[i].code} == key_i) begin
        hit_o = 1'b1;
        hit_idx_o = IW'(i);
      end
      if (!tab_q[i].valid) begin
        full_o = 1'b0;
        free_idx_o = IW'(i);
      end
      held_cnt_o = held_cnt_o + HW'(tab_q[i].valid);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_KEYS; i++) tab_q[i] <= '0;
    end else if (ins_i) begin
      tab_q[idx_i] <= '{valid: 1'b1, ext: key_i[8], code: key_i[7:0]};
    end else if (rem_i) begin
      tab_q[idx_i].valid <= 1'b0;
    end
  end
endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: decodes PS/2 make/break/E0/E1 sequences, tracks held keys, flags repeats, counts fresh presses; ports: clk, rst (async), bus (slave modport)
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int MAX_KEYS = 4,
  parameter int CNT_W = 8,
  parameter int PAUSE_LEN = 7
) (
  input logic clk,
  input logic rst,
  ps2_key_tracker_if.slave bus
);
  localparam int IW = (MAX_KEYS > 1) ? $clog2(MAX_KEYS) : 1;
  localparam int HW = $clog2(MAX_KEYS + 1);
  localparam int PW = $clog2(PAUSE_LEN + 1);
  state_t state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] press_q;
  logic [7:0] code_q;
  logic evt_q, ext_q, down_q, rep_q, pause_q, ovf_q;
  logic is_ext, is_pre, make, brk, pause_done, hit, full;
  logic [IW-1:0] hit_idx, free_idx;
  logic [HW-1:0] held;
  logic [7:0] d;
  assign d = bus.ps2_data;
  assign is_ext = state_q inside {S_EXT, S_EXT_BRK};
  assign is_pre = d inside {PS2_EXT, PS2_BRK, PS2_PAUSE};
  // In S_EXT only E0/F0 act as prefixes; E1 there is an ordinary extended code.
  assign make = bus.ps2_valid && ((state_q == S_BASE && !is_pre) ||
                (state_q == S_EXT && !(d inside {PS2_EXT, PS2_BRK})));
  assign brk = bus.ps2_valid && state_q inside {S_BRK, S_EXT_BRK};
  assign pause_done = bus.ps2_valid && state_q == S_PAUSE && pcnt_q == PW'(1);
  always_comb begin
    state_d = state_q;
    pcnt_d = pcnt_q;
    if (bus.ps2_valid) begin
      unique case (state_q)
        S_BASE: begin
          state_d = d == PS2_EXT ? S_EXT : d == PS2_BRK ? S_BRK : d == PS2_PAUSE ? S_PAUSE : S_BASE;
          pcnt_d = d == PS2_PAUSE ? PW'(PAUSE_LEN) : pcnt_q;
        end
        S_EXT: state_d = d == PS2_EXT ? S_EXT : d == PS2_BRK ? S_EXT_BRK : S_BASE;
        S_PAUSE: begin
          pcnt_d = pcnt_q - PW'(1);
          state_d = pcnt_q == PW'(1) ? S_BASE : S_PAUSE;
        end
        default: state_d = S_BASE;
      endcase
    end
  end
  ps2_key_table #(.MAX_KEYS(MAX_KEYS)) u_tab (
    .clk        (clk),
    .rst        (rst),
    .key_i      ({is_ext, d}),
    .ins_i      (make && !hit && !full),
    .rem_i      (brk && hit),
    .idx_i      (brk ? hit_idx : free_idx),
    .hit_o      (hit),
    .hit_idx_o  (hit_idx),
    .free_idx_o (free_idx),
    .full_o     (full),
    .held_cnt_o (held)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BASE;
      pcnt_q <= '0;
      press_q <= '0;
      code_q <= '0;
      evt_q <= 1'b0;
      ext_q <= 1'b0;
      down_q <= 1'b0;
      rep_q <= 1'b0;
      pause_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q <= pcnt_d;
      evt_q <= make || brk;
      pause_q <= pause_done;
      if (make || brk) begin
        code_q <= d;
        ext_q <= is_ext;
        down_q <= make;
        rep_q <= make && hit;
      end
      if (make && !hit) press_q <= press_q + CNT_W'(1);
      if (make && !hit && full) ovf_q <= 1'b1;
    end
  end
  assign bus.key_evt = evt_q;
  assign bus.key_code = code_q;
  assign bus.key_ext = ext_q;
  assign bus.key_down = down_q;
  assign bus.key_repeat = rep_q;
  assign bus.pause_evt = pause_q;
  assign bus.any_held = |held;
  assign bus.held_cnt = held;
  assign bus.press_cnt = press_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: directed byte sequences with a scoreboard queue checked by a decoupled event monitor
module tb_ps2_key_tracker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  typedef struct {
    bit         p;
    logic [7:0] code;
    bit         ext;
    bit         down;
    bit         rep;
    int         held;
    int         press;
    bit         ovf;
  } exp_t;
  exp_t q[$];
  exp_t e;
  ps2_key_tracker_if #(.MAX_KEYS(4), .CNT_W(8)) bus ();
  ps2_key_tracker #(.MAX_KEYS(4), .CNT_W(8), .PAUSE_LEN(7)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic ex(bit p, int code, bit ext, bit down, bit rep, int held, int press, bit ovf);
    q.push_back('{p: p, code: code[7:0], ext: ext, down: down, rep: rep, held: held, press: press, ovf: ovf});
  endtask
  task automatic send(logic [7:0] b);
    @(posedge clk);
    #1;
    bus.ps2_valid = 1'b1;
    bus.ps2_data = b;
  endtask
  task automatic idle();
    @(posedge clk);
    #1;
    bus.ps2_valid = 1'b0;
  endtask
  task automatic mk(logic [7:0] b, bit rep, int held, int press, bit ovf);
    ex(0, b, 0, 1, rep, held, press, ovf);
    send(b);
  endtask
  task automatic br(logic [7:0] b, int held, int press, bit ovf);
    send(8'hF0);
    ex(0, b, 0, 0, 0, held, press, ovf);
    send(b);
  endtask
  always @(negedge clk) begin
    if (!rst && (bus.key_evt || bus.pause_evt)) begin
      if (q.size() == 0) begin
        chk("unexpected_evt", 1, 0);
      end else begin
        e = q.pop_front();
        chk("pause_evt", int'(bus.pause_evt), int'(e.p));
        chk("key_evt", int'(bus.key_evt), int'(!e.p));
        if (!e.p) begin
          chk("key_code", int'(bus.key_code), int'(e.code));
          chk("key_ext", int'(bus.key_ext), int'(e.ext));
          chk("key_down", int'(bus.key_down), int'(e.down));
          chk("key_repeat", int'(bus.key_repeat), int'(e.rep));
          chk("held_cnt", int'(bus.held_cnt), e.held);
          chk("any_held", int'(bus.any_held), int'(e.held != 0));
          chk("press_cnt", int'(bus.press_cnt), e.press);
          chk("overflow", int'(bus.overflow), int'(e.ovf));
        end
      end
    end
  end
  initial begin
    bus.ps2_valid = 1'b0;
    bus.ps2_data = 8'h00;
    #12;
    chk("rst_key_evt", int'(bus.key_evt), 0);
    chk("rst_held_cnt", int'(bus.held_cnt), 0);
    chk("rst_press_cnt", int'(bus.press_cnt), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    rst = 1'b0;
    mk(8'h1C, 0, 1, 1, 0);
    br(8'h1C, 0, 1, 0);
    send(8'hE0);
    ex(0, 8'h75, 1, 1, 0, 1, 2, 0);
    send(8'h75);
    send(8'hE0);
    send(8'hF0);
    ex(0, 8'h75, 1, 0, 0, 0, 2, 0);
    send(8'h75);
    mk(8'h1C, 0, 1, 3, 0);
    mk(8'h1C, 1, 1, 3, 0);
    mk(8'h1C, 1, 1, 3, 0);
    br(8'h1C, 0, 3, 0);
    mk(8'h1C, 0, 1, 4, 0);
    mk(8'h1B, 0, 2, 5, 0);
    mk(8'h23, 0, 3, 6, 0);
    mk(8'h2B, 0, 4, 7, 0);
    mk(8'h34, 0, 4, 8, 1);
    br(8'h1B, 3, 8, 1);
    mk(8'h34, 0, 4, 9, 1);
    idle();
    #1;
    chk("slot1_code", int'(dut.u_tab.tab_q[1].code), 'h34);
    chk("slot1_valid", int'(dut.u_tab.tab_q[1].valid), 1);
    br(8'h1C, 3, 9, 1);
    br(8'h34, 2, 9, 1);
    br(8'h23, 1, 9, 1);
    br(8'h2B, 0, 9, 1);
    br(8'h55, 0, 9, 1);
    send(8'hE1);
    send(8'h14);
    send(8'h77);
    send(8'hE1);
    send(8'hF0);
    send(8'h14);
    send(8'hF0);
    ex(1, 0, 0, 0, 0, 0, 0, 0);
    send(8'h77);
    mk(8'h1C, 0, 1, 10, 1);
    idle();
    send(8'hF0);
    @(posedge clk);
    #2;
    bus.ps2_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_held_cnt", int'(bus.held_cnt), 0);
    chk("arst_any_held", int'(bus.any_held), 0);
    chk("arst_press_cnt", int'(bus.press_cnt), 0);
    chk("arst_overflow", int'(bus.overflow), 0);
    chk("arst_key_code", int'(bus.key_code), 0);
    #2;
    rst = 1'b0;
    mk(8'h1C, 0, 1, 1, 0);
    idle();
    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
